sobel_conv3x3: RTL and testbench
================================

Name: sobel_conv3x3

Overview:
Downstream consumer of the line-buffer shift registers in the image pipeline. Each accepted pixel arrives with the two vertically aligned pixels from the previous two rows, already delayed by the line buffers. The block assembles a 3x3 window, applies a selectable Sobel kernel (Gx or Gy), and emits the saturated absolute gradient. It is a fixed-latency, non-stalling pipeline with frame position tracking for border suppression.

Parameters:
WIDTH, 12, input pixel width (unsigned)
OUT_WIDTH, 12, output pixel width (unsigned)
IMG_W, 640, pixels per row
IMG_H, 480, rows per frame

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  input pixel strobe; one pixel accepted per cycle when high
i_row0  in  WIDTH  pixel (r, c), the newest row
i_row1  in  WIDTH  pixel (r-1, c), from line buffer 1
i_row2  in  WIDTH  pixel (r-2, c), from line buffer 2
i_kernel_sel  in  1  0 = Gx, 1 = Gy; sampled together with i_valid
o_valid  out  1  output pixel strobe
o_pixel  out  OUT_WIDTH  |gradient|, saturated
o_frame_done  out  1  one-cycle pulse coincident with the output of the last pixel of a frame

Behaviour:
- Clocking and reset: single clock i_clk. Reset is asynchronous and active-low on i_rst_n, and clears all state.
- Reset values: o_valid=0, o_pixel=0, o_frame_done=0. Window registers, counters and valid pipe also clear to 0.
- Window stage (edge k, i_valid=1):
  - Each row's 3-deep column register shifts: w[row][2] <= w[row][1], w[row][1] <= w[row][0], w[row][0] <= i_rowN.
  - Column 0 is the newest (c) and column 2 is the oldest (c-2). Row 0 is the newest and row 2 the oldest.
  - When i_valid=0, the window holds.
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1):
  - Advance on i_valid. col wraps to 0 at IMG_W-1 and increments row.
  - row wraps to 0 at IMG_H-1 together with col wrap, ending the frame.
  - The border flag is captured at edge k as (col<2 || row<2), using the pre-increment counter values.
  - The last-pixel flag is captured at edge k as (col==IMG_W-1 && row==IMG_H-1).
- Kernel stage (edge k+1):
  - Signed sum, width WIDTH+4, computed from the window.
  - Gx = (w0[0] + 2*w1[0] + w2[0]) - (w0[2] + 2*w1[2] + w2[2]).
  - Gy = (w0[0] + 2*w0[1] + w0[2]) - (w2[0] + 2*w2[1] + w2[2]).
  - Kernel select, border flag and last flag are pipelined alongside the data.
- Output stage (edge k+2):
  - o_pixel = border ? 0 : min(|sum|, 2^OUT_WIDTH - 1).
  - o_valid = 1 and o_frame_done = last flag; both are single-cycle.
- Latency: exactly 3 rising edges from input sample to output (k, k+1, k+2). Output is visible in the cycle after edge k+2.
- Flow control: no backpressure. Bubbles (i_valid=0) propagate as o_valid=0, and o_pixel holds its last value during bubbles. Throughput is 1 pixel per cycle.
- Border suppression: every accepted input yields exactly one output, including border positions, which output 0.
- Kernel switching: switching i_kernel_sel mid-frame affects only pixels sampled after the change.
- Reset mid-frame: the pipeline flushes, no o_valid is produced for in-flight pixels, and counters restart at (0,0).
- Simultaneous last pixel and new frame: the first pixel of the next frame may arrive on the cycle after the last one. Its counters are (0,0) and it is border-suppressed.

Decomposition:
- Package sobel_pkg:
  - kernel_sel_e enum {KERN_GX=0, KERN_GY=1}.
  - Localparam SUM_W offset (+4).
  - Function sat_abs(sum) returning OUT_WIDTH.
- Sub-module window3x3 (params WIDTH):
  - 3x3 register array with enable.
  - Inputs i_clk, i_rst_n, i_en, three column inputs; output is the packed 3x3 window.
- Counters, kernel arithmetic and output stage live in the top module.

Test Plan:
- Constant frame, all pixels 100 (IMG_W=8, IMG_H=6) -> all 48 outputs are 0, o_frame_done pulses exactly once, on output 48.
- Vertical step, cols 0-3 = 0 and cols 4-7 = 100, Gx -> interior cols 4 and 5 output 400; other interior cols output 0; cols 0-1 and rows 0-1 output 0.
- Horizontal step, rows 0-2 = 0 and rows 3-5 = 100, Gy -> rows 3 and 4 interior output 400; elsewhere 0. The same stimulus with Gx outputs all 0.
- Saturation: left 0 / right 4095 step, Gx -> sum 16380, o_pixel=4095. A negative step (left 4095 / right 0) also gives 4095 via abs.
- Latency and bubbles: i_valid toggled 1,0,0,1 -> o_valid follows the same pattern delayed by 3 cycles, and outputs match the gap-free run pixel-for-pixel.
- Reset mid-frame after 20 pixels -> o_valid=0 within the reset cycle; the subsequent full frame produces correct results and o_frame_done on pixel 48.

Source files
------------

// File: rtl/sobel_conv3x3_pkg.sv
// Shared types and helpers for the Sobel 3x3 gradient pipeline.
package sobel_pkg;

  typedef enum logic {
    KERN_GX = 1'b0,
    KERN_GY = 1'b1
  } kernel_sel_e;

  // Headroom bits of the signed kernel sum above the pixel width
  localparam int SUM_EXTRA = 4;

  function automatic logic [31:0] sat_abs(input logic signed [31:0] sum,
                                          input int unsigned        out_w);
    logic [31:0] mag;
    logic [31:0] lim;
    mag = sum[31] ? 32'(-sum) : 32'(sum);
    lim = (32'd1 << out_w) - 32'd1;
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/sobel_conv3x3_if.sv
// Pixel-stream bundle between the line buffers, the Sobel block and its consumer.
interface sobel_conv3x3_if #(
  parameter int WIDTH     = 12,
  parameter int OUT_WIDTH = 12
);
  logic                 i_valid;
  logic [WIDTH-1:0]     i_row0;
  logic [WIDTH-1:0]     i_row1;
  logic [WIDTH-1:0]     i_row2;
  logic                 i_kernel_sel;
  logic                 o_valid;
  logic [OUT_WIDTH-1:0] o_pixel;
  logic                 o_frame_done;

  modport master (
    output i_valid, i_row0, i_row1, i_row2, i_kernel_sel,
    input  o_valid, o_pixel, o_frame_done
  );

  modport slave (
    input  i_valid, i_row0, i_row1, i_row2, i_kernel_sel,
    output o_valid, o_pixel, o_frame_done
  );
endinterface

// File: rtl/sobel_conv3x3_window3x3.sv
// 3x3 pixel window: one 3-deep shift register per row, column 0 newest.
module window3x3 #(
  parameter int WIDTH = 12
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic [WIDTH-1:0]            i_col0,
  input  logic [WIDTH-1:0]            i_col1,
  input  logic [WIDTH-1:0]            i_col2,
  output logic [2:0][2:0][WIDTH-1:0]  o_win
);

  logic [2:0][WIDTH-1:0] col_in;

  assign col_in[0] = i_col0;
  assign col_in[1] = i_col1;
  assign col_in[2] = i_col2;

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    logic [2:0][WIDTH-1:0] row_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        row_q <= '0;
      end else if (i_en) begin
        row_q <= {row_q[1], row_q[0], col_in[gi]};
      end
    end

    assign o_win[gi] = row_q;
  end

endmodule

// File: rtl/sobel_conv3x3.sv
// Sobel Gx/Gy gradient magnitude over a streamed 3x3 window, 3-cycle fixed latency,
// with frame position tracking that zeroes the two leading rows and columns.
module sobel_conv3x3
  import sobel_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int OUT_WIDTH = 12,
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  sobel_conv3x3_if.slave bus
);

  localparam int SUM_W = WIDTH + SUM_EXTRA;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  // Stage 1: window, position and sideband
  logic [2:0][2:0][WIDTH-1:0] win;
  logic [COL_W-1:0]           col_q, col_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic                       v1_q, border1_q, last1_q;
  kernel_sel_e                ksel1_q;

  // Stage 2: kernel sum
  logic signed [SUM_W-1:0]    e [3][3];
  logic signed [SUM_W-1:0]    gx, gy, sum_d, sum_q;
  logic                       v2_q, border2_q, last2_q;

  // Stage 3: output
  logic [31:0]                sat_full;
  logic [OUT_WIDTH-1:0]       pix_d, pix_q;
  logic                       ovalid_q, fdone_q;

  window3x3 #(.WIDTH(WIDTH)) u_window (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (bus.i_valid),
    .i_col0  (bus.i_row0),
    .i_col1  (bus.i_row1),
    .i_col2  (bus.i_row2),
    .o_win   (win)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (bus.i_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Flags use the position of the pixel being accepted, before the counters advance
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      v1_q      <= 1'b0;
      border1_q <= 1'b0;
      last1_q   <= 1'b0;
      ksel1_q   <= KERN_GX;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      v1_q  <= bus.i_valid;
      if (bus.i_valid) begin
        border1_q <= (col_q < COL_TWO) || (row_q < ROW_TWO);
        last1_q   <= (col_q == COL_LAST) && (row_q == ROW_LAST);
        ksel1_q   <= kernel_sel_e'(bus.i_kernel_sel);
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_ext_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_ext_col
      assign e[gi][gj] = signed'({{SUM_EXTRA{1'b0}}, win[gi][gj]});
    end
  end

  always_comb begin
    gx    = (e[0][0] + (e[1][0] <<< 1) + e[2][0]) - (e[0][2] + (e[1][2] <<< 1) + e[2][2]);
    gy    = (e[0][0] + (e[0][1] <<< 1) + e[0][2]) - (e[2][0] + (e[2][1] <<< 1) + e[2][2]);
    sum_d = (ksel1_q == KERN_GY) ? gy : gx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q     <= '0;
      v2_q      <= 1'b0;
      border2_q <= 1'b0;
      last2_q   <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        sum_q     <= sum_d;
        border2_q <= border1_q;
        last2_q   <= last1_q;
      end
    end
  end

  always_comb begin
    sat_full = sat_abs({{(32 - SUM_W){sum_q[SUM_W-1]}}, sum_q}, OUT_WIDTH);
    pix_d    = sat_full[OUT_WIDTH-1:0];
    if (|sat_full[31:OUT_WIDTH]) begin
      pix_d = '1;
    end
    if (border2_q) begin
      pix_d = '0;
    end
  end

  // o_pixel only moves with a real output so it holds through bubbles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_q    <= '0;
      ovalid_q <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      ovalid_q <= v2_q;
      fdone_q  <= v2_q & last2_q;
      if (v2_q) begin
        pix_q <= pix_d;
      end
    end
  end

  assign bus.o_valid      = ovalid_q;
  assign bus.o_pixel      = pix_q;
  assign bus.o_frame_done = fdone_q;

endmodule

// File: tb/tb_sobel_conv3x3.sv
// Randomized scoreboard bench for sobel_conv3x3 on a small 8x6 frame.
module tb_sobel_conv3x3;

  localparam int WIDTH     = 12;
  localparam int OUT_WIDTH = 12;
  localparam int IMG_W     = 8;
  localparam int IMG_H     = 6;
  localparam int LAT       = 3;
  localparam int MAXV      = 4095;

  typedef struct {
    int pix;
    bit last;
    int stamp;
    int r;
    int c;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_conv3x3_if #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

  sobel_conv3x3 #(
    .WIDTH     (WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  exp_t exp_q[$];
  exp_t got_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_out = 0;
  int   n_fd  = 0;
  int   n_400 = 0;
  int   n_sat = 0;
  int   n_nz  = 0;
  int   img[IMG_H][IMG_W];
  logic [OUT_WIDTH-1:0] held_pix = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: gradient straight from frame coordinates
  function automatic int ref_pix(int r, int c, bit k);
    int g;
    if (r < 2 || c < 2) return 0;
    if (!k)
      g = (img[r][c] + 2*img[r-1][c] + img[r-2][c]) - (img[r][c-2] + 2*img[r-1][c-2] + img[r-2][c-2]);
    else
      g = (img[r][c] + 2*img[r][c-1] + img[r][c-2]) - (img[r-2][c] + 2*img[r-2][c-1] + img[r-2][c-2]);
    if (g < 0) g = -g;
    if (g > MAXV) g = MAXV;
    return g;
  endfunction

  function automatic int pat(int mode, int r, int c);
    case (mode)
      0:       return 100;
      1:       return (c >= 4) ? 100 : 0;
      2:       return (r >= 3) ? 100 : 0;
      3:       return (c >= 4) ? MAXV : 0;
      4:       return (c >= 4) ? 0 : MAXV;
      default: return int'($urandom_range(MAXV));
    endcase
  endfunction

  task automatic fill(int mode);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = pat(mode, r, c);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.i_valid      = 1'b0;
      bus.i_row0       = WIDTH'($urandom_range(MAXV));
      bus.i_row1       = WIDTH'($urandom_range(MAXV));
      bus.i_row2       = WIDTH'($urandom_range(MAXV));
      bus.i_kernel_sel = 1'($urandom_range(1));
    end
  endtask

  task automatic send(int r, int c, bit k);
    @(posedge clk); #1;
    bus.i_valid      = 1'b1;
    bus.i_row0       = WIDTH'(img[r][c]);
    bus.i_row1       = (r >= 1) ? WIDTH'(img[r-1][c]) : WIDTH'($urandom_range(MAXV));
    bus.i_row2       = (r >= 2) ? WIDTH'(img[r-2][c]) : WIDTH'($urandom_range(MAXV));
    bus.i_kernel_sel = k;
    exp_q.push_back('{ref_pix(r, c, k), (r == IMG_H-1 && c == IMG_W-1), cyc, r, c});
  endtask

  // kmode: 0 Gx, 1 Gy, 2 random per pixel; gap: 0 none, 1 random, 2 two bubbles per pixel
  task automatic run_frame(int kmode, int gap, int npix);
    int  idx;
    bit  k;
    idx = 0;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (idx < npix) begin
          if (gap == 1 && $urandom_range(3) == 0) idle(int'($urandom_range(1, 3)));
          if (gap == 2 && idx > 0) idle(2);
          k = (kmode == 2) ? 1'($urandom_range(1)) : 1'(kmode);
          send(r, c, k);
        end
        idx++;
      end
    end
  endtask

  task automatic drain();
    int n;
    idle(1);
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic clear_counts();
    n_out = 0; n_fd = 0; n_400 = 0; n_sat = 0; n_nz = 0;
  endtask

  task automatic check_int(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d required=%0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      total++;
      if (bus.o_valid !== 1'b0 || bus.o_frame_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs: valid=%b done=%b required 0 0", bus.o_valid, bus.o_frame_done);
      end
      held_pix = '0;
    end else if (bus.o_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: pixel=%0d with no pending input", bus.o_pixel);
      end else begin
        got_e = exp_q.pop_front();
        if (bus.o_pixel !== OUT_WIDTH'(got_e.pix) || bus.o_frame_done !== got_e.last ||
            (cyc - got_e.stamp) != LAT) begin
          bad++;
          $display("FAIL out r=%0d c=%0d: pixel=%0d required=%0d done=%b required=%b latency=%0d required=%0d",
                   got_e.r, got_e.c, bus.o_pixel, got_e.pix, bus.o_frame_done, got_e.last,
                   cyc - got_e.stamp, LAT);
        end else begin
          $display("out r=%0d c=%0d pixel=%0d done=%b", got_e.r, got_e.c, bus.o_pixel, bus.o_frame_done);
        end
      end
      n_out++;
      if (bus.o_frame_done) n_fd++;
      if (bus.o_pixel == 400) n_400++;
      if (bus.o_pixel == OUT_WIDTH'(MAXV)) n_sat++;
      if (bus.o_pixel != 0) n_nz++;
      held_pix = bus.o_pixel;
    end else begin
      total++;
      if (bus.o_pixel !== held_pix || bus.o_frame_done !== 1'b0) begin
        bad++;
        $display("FAIL bubble_hold: pixel=%0d required=%0d done=%b required=0",
                 bus.o_pixel, held_pix, bus.o_frame_done);
      end
    end
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bus.i_valid      = 1'b0;
    bus.i_row0       = '0;
    bus.i_row1       = '0;
    bus.i_row2       = '0;
    bus.i_kernel_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_o_valid", int'(bus.o_valid), 0);
    check_int("reset_o_pixel", int'(bus.o_pixel), 0);
    check_int("reset_o_frame_done", int'(bus.o_frame_done), 0);
    rst_n = 1'b1;

    // Flat frame: every gradient is zero, one frame_done on the last output
    clear_counts(); fill(0); run_frame(2, 0, IMG_W*IMG_H); drain();
    check_int("const_outputs", n_out, 48);
    check_int("const_nonzero", n_nz, 0);
    check_int("const_frame_done", n_fd, 1);

    clear_counts(); fill(1); run_frame(0, 0, IMG_W*IMG_H); drain();
    check_int("vstep_gx_400", n_400, 8);
    check_int("vstep_gx_nonzero", n_nz, 8);

    clear_counts(); fill(2); run_frame(1, 0, IMG_W*IMG_H); drain();
    check_int("hstep_gy_400", n_400, 12);
    check_int("hstep_gy_nonzero", n_nz, 12);

    clear_counts(); fill(2); run_frame(0, 0, IMG_W*IMG_H); drain();
    check_int("hstep_gx_nonzero", n_nz, 0);

    clear_counts(); fill(3); run_frame(0, 0, IMG_W*IMG_H); drain();
    check_int("sat_pos_count", n_sat, 8);

    clear_counts(); fill(4); run_frame(0, 0, IMG_W*IMG_H); drain();
    check_int("sat_neg_count", n_sat, 8);

    // Same image gap-free and with 1,0,0,1 bubbles
    fill(5);
    clear_counts(); run_frame(0, 0, IMG_W*IMG_H); drain();
    clear_counts(); run_frame(0, 2, IMG_W*IMG_H); drain();
    check_int("bubble_outputs", n_out, 48);
    check_int("bubble_frame_done", n_fd, 1);

    clear_counts(); fill(5); run_frame(2, 1, IMG_W*IMG_H); drain();
    check_int("rand_gap_outputs", n_out, 48);

    // Back-to-back frames, first pixel of frame 2 right after the last of frame 1
    clear_counts();
    fill(5); run_frame(2, 0, IMG_W*IMG_H);
    fill(5); run_frame(2, 0, IMG_W*IMG_H);
    drain();
    check_int("b2b_outputs", n_out, 96);
    check_int("b2b_frame_done", n_fd, 2);

    // Reset after 20 pixels: in-flight pixels vanish, next frame starts at (0,0)
    fill(5); run_frame(2, 0, 20);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_int("midreset_o_valid", int'(bus.o_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_counts(); fill(5); run_frame(2, 0, IMG_W*IMG_H); drain();
    check_int("post_reset_outputs", n_out, 48);
    check_int("post_reset_frame_done", n_fd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
